// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I-subset control FSM (lw, sw, R-ALU, I-ALU, beq, jal).
// This is a Moore machine. Per-state controls are registered together with the state,
// so they are valid from the start of each state.
// PCWrite uses the ALU zero flag, so it stays combinational.
// ALUControl and ImmSrc are also combinational, because they depend on op/funct.
module riscv_mc_controller #(
  parameter int ILLEGAL_TRAP = 1,
  parameter int STATE_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
  } state_t;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  state_t r_state;
  state_t w_state_next;
  ctrl_t  r_ctrl;
  logic [2:0] w_alu_control;
  logic [1:0] w_imm_src;

  // Control word for each state; anything not set stays 0.
  function automatic ctrl_t f_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.pc_update  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BEQ: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      S_HALT:     c.illegal = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic; op is only consulted in DECODE and MEMADR, so an X in FETCH is harmless.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH:    w_state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_state_next = S_MEMADR;
          OP_R:         w_state_next = S_EXECR;
          OP_I:         w_state_next = S_EXECI;
          OP_BEQ:       w_state_next = S_BEQ;
          OP_JAL:       w_state_next = S_JAL;
          default:      w_state_next = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;
        endcase
      end
      // op[5] separates sw (0100011) from lw (0000011)
      S_MEMADR:   w_state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_state_next = S_MEMWB;
      S_MEMWB:    w_state_next = S_FETCH;
      S_MEMWRITE: w_state_next = S_FETCH;
      S_EXECR:    w_state_next = S_ALUWB;
      S_EXECI:    w_state_next = S_ALUWB;
      S_JAL:      w_state_next = S_ALUWB;
      S_ALUWB:    w_state_next = S_FETCH;
      S_BEQ:      w_state_next = S_FETCH;
      S_HALT:     w_state_next = S_HALT;
      default:    w_state_next = S_FETCH;
    endcase
  end

  // State and registered control word; reset forces FETCH and its controls immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_ctrl  <= f_ctrl(S_FETCH);
    end else begin
      r_state <= w_state_next;
      r_ctrl  <= f_ctrl(w_state_next);
    end
  end

  // ALU decoder: ALUOp selects add/sub directly or defers to funct3 for ALU instructions.
  always_comb begin
    w_alu_control = 3'b000;
    case (r_ctrl.alu_op)
      2'b00: w_alu_control = 3'b000;
      2'b01: w_alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  w_alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  w_alu_control = 3'b101;
          3'b110:  w_alu_control = 3'b011;
          3'b111:  w_alu_control = 3'b010;
          default: w_alu_control = 3'b000;
        endcase
      end
      default: w_alu_control = 3'b000;
    endcase
  end

  // Immediate format select straight from the opcode.
  always_comb begin
    w_imm_src = 2'b00;
    case (op)
      OP_SW:   w_imm_src = 2'b01;
      OP_BEQ:  w_imm_src = 2'b10;
      OP_JAL:  w_imm_src = 2'b11;
      default: w_imm_src = 2'b00;
    endcase
  end

  assign PCWrite    = r_ctrl.pc_update | (r_ctrl.branch & zero);
  assign AdrSrc     = r_ctrl.adr_src;
  assign MemWrite   = r_ctrl.mem_write;
  assign IRWrite    = r_ctrl.ir_write;
  assign RegWrite   = r_ctrl.reg_write;
  assign ResultSrc  = r_ctrl.result_src;
  assign ALUSrcA    = r_ctrl.alu_src_a;
  assign ALUSrcB    = r_ctrl.alu_src_b;
  assign ImmSrc     = w_imm_src;
  assign ALUControl = w_alu_control;
  assign illegal    = r_ctrl.illegal;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Scoreboard bench for riscv_mc_controller.
// Two instances are driven from the same inputs, one with trap enabled and one with NOP behaviour.
// Every cycle, the stimulus pushes the expected output vector of each instance.
// A negedge monitor then pops each entry and compares it.
module tb_riscv_mc_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic       pcw_t, adr_t, mw_t, irw_t, rw_t, ill_t;
  logic [1:0] rs_t, sa_t, sb_t, imm_t;
  logic [2:0] alu_t;
  logic       pcw_n, adr_n, mw_n, irw_n, rw_n, ill_n;
  logic [1:0] rs_n, sa_n, sb_n, imm_n;
  logic [2:0] alu_n;

  riscv_mc_controller #(.ILLEGAL_TRAP(1), .STATE_W(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PCWrite(pcw_t), .AdrSrc(adr_t), .MemWrite(mw_t), .IRWrite(irw_t), .RegWrite(rw_t),
    .ResultSrc(rs_t), .ALUSrcA(sa_t), .ALUSrcB(sb_t), .ImmSrc(imm_t),
    .ALUControl(alu_t), .illegal(ill_t)
  );

  riscv_mc_controller #(.ILLEGAL_TRAP(0), .STATE_W(4)) dut_n (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PCWrite(pcw_n), .AdrSrc(adr_n), .MemWrite(mw_n), .IRWrite(irw_n), .RegWrite(rw_n),
    .ResultSrc(rs_n), .ALUSrcA(sa_n), .ALUSrcB(sb_n), .ImmSrc(imm_n),
    .ALUControl(alu_n), .illegal(ill_n)
  );

  always #5 clk = ~clk;

  // Vector layout: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl illegal
  wire [16:0] act_t = {pcw_t, adr_t, mw_t, irw_t, rw_t, rs_t, sa_t, sb_t, imm_t, alu_t, ill_t};
  wire [16:0] act_n = {pcw_n, adr_n, mw_n, irw_n, rw_n, rs_n, sa_n, sb_n, imm_n, alu_n, ill_n};

  typedef enum int {P_F, P_D, P_MA, P_MR, P_MW, P_MWR, P_ER, P_EI, P_AW, P_B, P_J, P_H} phase_e;
  typedef phase_e plan_t[$];

  typedef struct {
    string       name;
    logic [16:0] exp_t;
    logic [16:0] exp_n;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic void check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endfunction

  // Sequence of phases an instruction walks through, derived from its opcode.
  function automatic plan_t plan_for(input logic [6:0] o, input bit trap);
    plan_t p;
    p.push_back(P_F);
    p.push_back(P_D);
    case (o)
      OP_LW:  begin p.push_back(P_MA); p.push_back(P_MR); p.push_back(P_MW); end
      OP_SW:  begin p.push_back(P_MA); p.push_back(P_MWR); end
      OP_R:   begin p.push_back(P_ER); p.push_back(P_AW); end
      OP_I:   begin p.push_back(P_EI); p.push_back(P_AW); end
      OP_BEQ: p.push_back(P_B);
      OP_JAL: begin p.push_back(P_J); p.push_back(P_AW); end
      default: if (trap) p.push_back(P_H);
    endcase
    return p;
  endfunction

  // Beyond the plan, a trapped instance remains in HALT.
  // A NOP instance refetches the same held opcode and repeats its plan.
  function automatic phase_e phase_at(input plan_t p, input int i, input bit trap);
    if (i < p.size()) return p[i];
    if (trap) return P_H;
    return p[i % p.size()];
  endfunction

  function automatic logic [16:0] exp_vec(input phase_e p, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7, input logic z);
    logic pcu, br, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sbv, aop, imm;
    logic [2:0] alu;
    {pcu, br, adr, mw, irw, rw, ill} = '0;
    {rs, sa, sbv, aop} = '0;
    case (p)
      P_F:   begin irw = 1; sbv = 2'b10; rs = 2'b10; pcu = 1; end
      P_D:   begin sa = 2'b01; sbv = 2'b01; end
      P_MA:  begin sa = 2'b10; sbv = 2'b01; end
      P_MR:  adr = 1;
      P_MW:  begin rs = 2'b01; rw = 1; end
      P_MWR: begin adr = 1; mw = 1; end
      P_ER:  begin sa = 2'b10; aop = 2'b10; end
      P_EI:  begin sa = 2'b10; sbv = 2'b01; aop = 2'b10; end
      P_AW:  rw = 1;
      P_B:   begin sa = 2'b10; aop = 2'b01; br = 1; end
      P_J:   begin sa = 2'b01; sbv = 2'b10; pcu = 1; end
      P_H:   ill = 1;
      default: ;
    endcase
    alu = 3'b000;
    if (aop == 2'b01) alu = 3'b001;
    else if (aop == 2'b10) begin
      case (f3)
        3'b000: alu = (o[5] && f7) ? 3'b001 : 3'b000;
        3'b010: alu = 3'b101;
        3'b110: alu = 3'b011;
        3'b111: alu = 3'b010;
        default: alu = 3'b000;
      endcase
    end
    case (o)
      OP_SW:   imm = 2'b01;
      OP_BEQ:  imm = 2'b10;
      OP_JAL:  imm = 2'b11;
      default: imm = 2'b00;
    endcase
    return {pcu | (br & z), adr, mw, irw, rw, rs, sa, sbv, imm, alu, ill};
  endfunction

  function automatic logic pick_zero(input int zmode);
    if (zmode == 1) return 1'b1;
    if (zmode == 2) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  // Issue one instruction (ncyc=0: natural length), pushing expectations per cycle.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input int ncyc, input int zmode);
    plan_t pt, pn;
    int n;
    sb_entry_t e;
    pt = plan_for(o, 1'b1);
    pn = plan_for(o, 1'b0);
    n = (ncyc > 0) ? ncyc : pt.size();
    $display("instr %s op=%b f3=%b f7b5=%b cycles=%0d", name, o, f3, f7, n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      op = o; funct3 = f3; funct7b5 = f7;
      zero = pick_zero(zmode);
      e.name  = $sformatf("%s c%0d", name, i + 1);
      e.exp_t = exp_vec(phase_at(pt, i, 1'b1), o, f3, f7, zero);
      e.exp_n = exp_vec(phase_at(pn, i, 1'b0), o, f3, f7, zero);
      sb.push_back(e);
    end
  endtask

  // Hold reset for some cycles; outputs must show FETCH values throughout.
  task automatic hold_reset(input int ncyc);
    sb_entry_t e;
    $display("reset cycles=%0d", ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      zero = pick_zero(0);
      e.name  = $sformatf("reset c%0d", i + 1);
      e.exp_t = exp_vec(P_F, op, funct3, funct7b5, zero);
      e.exp_n = e.exp_t;
      sb.push_back(e);
    end
  endtask

  // Monitor: compare both instances against the queued expectation every cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_entry_t e;
      e = sb.pop_front();
      check({e.name, " trap"}, act_t, e.exp_t);
      check({e.name, " nop"},  act_n, e.exp_n);
    end
  end

  initial begin
    logic [6:0] ops [6];
    logic [2:0] f3s [5];
    logic [6:0] o;
    logic [2:0] f3;
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R;
    ops[3] = OP_I;  ops[4] = OP_BEQ; ops[5] = OP_JAL;
    f3s[0] = 3'b000; f3s[1] = 3'b010; f3s[2] = 3'b110; f3s[3] = 3'b111; f3s[4] = 3'b000;

    rst_n = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
    hold_reset(2);

    run_instr("lw",      OP_LW,  3'b010, 1'b0, 0, 0);
    run_instr("sw",      OP_SW,  3'b010, 1'b1, 0, 0);
    run_instr("sub",     OP_R,   3'b000, 1'b1, 0, 0);
    run_instr("add",     OP_R,   3'b000, 1'b0, 0, 0);
    run_instr("slt",     OP_R,   3'b010, 1'b0, 0, 0);
    run_instr("or",      OP_R,   3'b110, 1'b0, 0, 0);
    run_instr("and",     OP_R,   3'b111, 1'b0, 0, 0);
    run_instr("addi",    OP_I,   3'b000, 1'b1, 0, 0);
    run_instr("beq_tk",  OP_BEQ, 3'b000, 1'b0, 0, 1);
    run_instr("beq_nt",  OP_BEQ, 3'b000, 1'b0, 0, 2);
    run_instr("jal",     OP_JAL, 3'b000, 1'b0, 0, 0);

    // Abandon a lw in MEMREAD with an asynchronous reset.
    run_instr("lw_abort", OP_LW, 3'b010, 1'b0, 4, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset IRWrite",  {16'd0, irw_t}, 17'd1);
    check("async reset PCWrite",  {16'd0, pcw_t}, 17'd1);
    check("async reset RegWrite", {16'd0, rw_t},  17'd0);
    hold_reset(1);
    run_instr("addi_after_rst", OP_I, 3'b111, 1'b0, 0, 0);

    // Randomized instruction mix.
    for (int k = 0; k < 80; k++) begin
      o  = ops[$urandom_range(0, 5)];
      f3 = f3s[$urandom_range(0, 4)];
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      run_instr($sformatf("rnd%0d", k), o, f3, 1'($urandom_range(0, 1)), 0, 0);
    end

    // Unsupported opcode: trap instance parks in HALT, NOP instance keeps refetching.
    run_instr("illegal", OP_BAD, 3'b000, 1'b0, 5, 0);
    hold_reset(1);
    run_instr("jal_after_halt", OP_JAL, 3'b000, 1'b0, 0, 0);
    run_instr("lw_last",        OP_LW,  3'b010, 1'b0, 0, 0);

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard drain: %0d entries left, 0 expected", sb.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, still running");
    $fatal(1, "timeout");
  end

endmodule
